// File: rtl/uart_rx_timing_ctrl.sv
// UART receive front end: synchronizes the RX line, detects start bits and
// times the mid-bit samples that drive the downstream shift register.
module uart_rx_timing_ctrl #(
  parameter int TIMER_WIDTH = 14,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   serial_in,
  input  logic [TIMER_WIDTH-1:0] bit_period,
  input  logic [CNT_WIDTH-1:0]   data_size,
  output logic                   rx_bit,
  output logic                   shift_enable,
  output logic                   load_buffer,
  output logic                   framing_error,
  output logic                   busy
);

  localparam logic [TIMER_WIDTH-1:0] BP_MIN  = TIMER_WIDTH'(4);
  localparam logic [TIMER_WIDTH-1:0] T_ONE   = TIMER_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]   N_MIN   = CNT_WIDTH'(5);
  localparam logic [CNT_WIDTH-1:0]   N_MAX   = CNT_WIDTH'(8);
  localparam logic [CNT_WIDTH-1:0]   C_ONE   = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_CHK,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;

  logic                   r_sync1;
  logic                   r_sync2;
  logic                   r_prev;
  logic [1:0]             r_primed;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic [TIMER_WIDTH-1:0] r_bp;
  logic [CNT_WIDTH-1:0]   r_n;
  logic [CNT_WIDTH-1:0]   r_bit_cnt;
  logic                   r_fe;

  logic [TIMER_WIDTH-1:0] w_bp_clamped;
  logic [CNT_WIDTH-1:0]   w_n_clamped;
  logic [TIMER_WIDTH-1:0] w_target;
  logic                   w_expire;
  logic                   w_start;
  logic                   w_stop_fail;
  logic                   w_shift;

  // r_primed marks when r_sync2 holds a real line sample rather than its
  // reset value, so a line held low across reset never looks like an edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_prev   <= 1'b0;
      r_primed <= 2'b00;
    end else begin
      r_sync1  <= serial_in;
      r_sync2  <= r_sync1;
      r_prev   <= r_primed[1] ? r_sync2 : 1'b0;
      r_primed <= {r_primed[0], 1'b1};
    end
  end

  assign rx_bit = r_sync2;

  assign w_bp_clamped = (bit_period < BP_MIN) ? BP_MIN : bit_period;
  assign w_n_clamped  = (data_size >= N_MIN && data_size <= N_MAX) ? data_size : N_MAX;

  assign w_target = (r_state == S_START_CHK) ? {1'b0, r_bp[TIMER_WIDTH-1:1]} : r_bp;
  assign w_expire = (r_timer == (w_target - T_ONE));

  assign w_start     = (r_state == S_IDLE) && !r_sync2 && r_prev;
  assign w_shift     = (r_state == S_DATA) && w_expire;
  assign w_stop_fail = (r_state == S_STOP) && w_expire && !r_sync2;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_next = S_START_CHK;
      end
      S_START_CHK: begin
        if (w_expire) w_state_next = r_sync2 ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_expire && (r_bit_cnt == (r_n - C_ONE))) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_expire) w_state_next = r_sync2 ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_timer   <= '0;
      r_bp      <= '0;
      r_n       <= '0;
      r_bit_cnt <= '0;
      r_fe      <= 1'b0;
    end else begin
      if ((w_state_next != r_state) || w_expire || (r_state == S_IDLE)) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + T_ONE;
      end

      // Frame configuration is frozen at the start edge.
      if (w_start) begin
        r_bp      <= w_bp_clamped;
        r_n       <= w_n_clamped;
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + C_ONE;
      end

      if (w_start) begin
        r_fe <= 1'b0;
      end else if (w_stop_fail) begin
        r_fe <= 1'b1;
      end
    end
  end

  assign shift_enable  = w_shift;
  assign load_buffer   = (r_state == S_DONE);
  assign busy          = (r_state != S_IDLE);
  // Rises in the failing stop-sample cycle and drops in the next start cycle.
  assign framing_error = (r_fe && !w_start) || w_stop_fail;

endmodule

// File: tb/tb_uart_rx_timing_ctrl.sv
// Scoreboard bench for uart_rx_timing_ctrl: directed frames push expected
// pulse events; a negedge monitor pops and compares them as the DUT emits.
module tb_uart_rx_timing_ctrl;

  logic        clk;
  logic        n_rst;
  logic        serial_in;
  logic [13:0] bit_period;
  logic [3:0]  data_size;
  logic        rx_bit;
  logic        shift_enable;
  logic        load_buffer;
  logic        framing_error;
  logic        busy;

  uart_rx_timing_ctrl #(.TIMER_WIDTH(14), .CNT_WIDTH(4)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .bit_period    (bit_period),
    .data_size     (data_size),
    .rx_bit        (rx_bit),
    .shift_enable  (shift_enable),
    .load_buffer   (load_buffer),
    .framing_error (framing_error),
    .busy          (busy)
  );

  // kind: 0 = shift_enable, 1 = load_buffer, 2 = framing_error rising
  typedef struct {
    int   kind;
    int   cyc;
    logic bitv;
  } ev_t;

  ev_t exp_q[$];
  int  cyc   = 0;
  int  n_cmp = 0;
  int  n_err = 0;
  logic fe_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  task automatic check_ev(input int kind, input logic b);
    ev_t ev;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind %0d at cyc %0d, required no event", kind, cyc);
    end else begin
      ev = exp_q.pop_front();
      if (ev.kind != kind || ev.cyc != cyc || (kind == 0 && ev.bitv !== b)) begin
        n_err++;
        $display("FAIL event: got kind %0d cyc %0d bit %0b, required kind %0d cyc %0d bit %0b",
                 kind, cyc, b, ev.kind, ev.cyc, ev.bitv);
      end
    end
  endtask

  // Monitor: decoupled from stimulus, samples on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (shift_enable) check_ev(0, rx_bit);
      if (load_buffer) check_ev(1, 1'b0);
      if (framing_error && !fe_prev) check_ev(2, 1'b0);
      fe_prev = framing_error;
    end
  end

  task automatic hold(input logic v, input int n);
    serial_in = v;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic goto_neg(input int c);
    forever begin
      @(negedge clk);
      if (cyc >= c) break;
    end
  endtask

  // bpe/ne are the hand-clamped effective period and bit count.
  task automatic send_frame(input int bp_raw, input int bpe, input int n_raw, input int ne,
                            input logic [7:0] d, input logic stop_v, input int abort_bits);
    int c0, e, half, stop_s;
    bit_period = 14'(bp_raw);
    data_size  = 4'(n_raw);
    @(posedge clk);
    #2;
    c0     = cyc;
    e      = c0 + 2;
    half   = bpe / 2;
    stop_s = e + half + (ne + 1) * bpe;
    for (int k = 0; k < ne; k++) begin
      if (abort_bits < 0 || k < abort_bits) exp_q.push_back('{0, e + half + (k + 1) * bpe, d[k]});
    end
    if (abort_bits < 0) begin
      if (stop_v) exp_q.push_back('{1, stop_s + 1, 1'b0});
      else        exp_q.push_back('{2, stop_s, 1'b0});
    end
    $display("frame: bp=%0d n=%0d data=0x%02h stop=%0b abort=%0d E=%0d", bp_raw, n_raw, d, stop_v, abort_bits, e);
    if (abort_bits >= 0) begin
      hold(1'b0, bpe);
      for (int k = 0; k < abort_bits; k++) hold(d[k], bpe);
      n_rst     = 1'b0;
      serial_in = 1'b1;
      #1;
      chk("abort_rx_bit", rx_bit, 1);
      chk("abort_shift", shift_enable, 0);
      chk("abort_load", load_buffer, 0);
      chk("abort_fe", framing_error, 0);
      chk("abort_busy", busy, 0);
      hold(1'b1, 3);
      n_rst = 1'b1;
      hold(1'b1, 10);
    end else begin
      fork
        begin
          hold(1'b0, bpe);
          for (int k = 0; k < ne; k++) hold(d[k], bpe);
          hold(stop_v, bpe);
          hold(1'b1, 4);
        end
        begin
          goto_neg(e);
          chk("fe_clear_at_E", framing_error, 0);
          chk("busy_at_E", busy, 0);
          goto_neg(e + 1);
          chk("busy_at_E+1", busy, 1);
          if (stop_v) begin
            goto_neg(stop_s + 1);
            chk("busy_at_load", busy, 1);
            goto_neg(stop_s + 2);
            chk("busy_after_load", busy, 0);
            chk("fe_good_frame", framing_error, 0);
          end else begin
            goto_neg(stop_s + 1);
            chk("busy_after_ferr", busy, 0);
            chk("fe_held", framing_error, 1);
          end
        end
      join
    end
  endtask

  task automatic send_glitch();
    int c0, e;
    bit_period = 14'd10;
    data_size  = 4'd8;
    @(posedge clk);
    #2;
    c0 = cyc;
    e  = c0 + 2;
    $display("glitch: 3-cycle low pulse, bp=10, E=%0d", e);
    fork
      begin
        hold(1'b0, 3);
        hold(1'b1, 12);
      end
      begin
        goto_neg(e + 1);
        chk("glitch_busy_E+1", busy, 1);
        goto_neg(e + 5);
        chk("glitch_busy_E+5", busy, 1);
        goto_neg(e + 6);
        chk("glitch_busy_E+6", busy, 0);
        chk("glitch_fe", framing_error, 0);
      end
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst      = 1'b0;
    serial_in  = 1'b0;
    bit_period = 14'd10;
    data_size  = 4'd8;
    repeat (3) @(negedge clk);
    chk("reset_rx_bit", rx_bit, 1);
    chk("reset_shift", shift_enable, 0);
    chk("reset_load", load_buffer, 0);
    chk("reset_fe", framing_error, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk);
    #2;
    n_rst = 1'b1;
    $display("reset released with line low");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("low_after_reset_busy", busy, 0);
    end
    @(posedge clk);
    #2;
    hold(1'b1, 6);

    send_frame(10, 10, 8, 8, 8'hA5, 1'b1, -1);
    send_frame(10, 10, 8, 8, 8'hA5, 1'b0, -1);
    send_frame(10, 10, 8, 8, 8'h3C, 1'b1, -1);
    send_glitch();
    send_frame(2, 4, 5, 5, 8'h13, 1'b1, -1);
    send_frame(2, 4, 12, 8, 8'hC6, 1'b1, -1);
    send_frame(10, 10, 8, 8, 8'hF0, 1'b1, 3);
    send_frame(10, 10, 8, 8, 8'h5A, 1'b1, -1);

    hold(1'b1, 20);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
